// File: rtl/snoopy_pkg.sv
// Shared Snoopy definitions: screen geometry, coordinate widths and the
// vertical-motion state encodings decoded by the renderer and collision logic.
package snoopy_pkg;
   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam int VEL_W    = 5;

   localparam logic [1:0] S_GROUND = 2'b00;
   localparam logic [1:0] S_RISE   = 2'b01;
   localparam logic [1:0] S_FALL   = 2'b10;
endpackage

// File: rtl/snoopy_edge_detect.sv
// One-bit rising-edge detector: the pulse is valid in the same cycle the
// input first goes high, relative to the registered previous value.
module snoopy_edge_detect (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic rise
);
   logic prev_q;
   logic prev_d;

   always_comb begin
      prev_d = din;
      rise   = din & ~prev_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
      end
   end
endmodule

// File: rtl/snoopy_vertical_fsm.sv
// Vertical motion controller for Snoopy: turns jump presses into a gravity
// arc, advancing y and velocity once per frame tick.
module snoopy_vertical_fsm
   import snoopy_pkg::*;
#(
   parameter int GROUND_Y     = 100,
   parameter int MIN_Y        = 0,
   parameter int JUMP_VEL     = 6,
   parameter int GRAVITY      = 1,
   parameter int MAX_FALL_VEL = 6
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           frame_tick,
   input  logic           input_jump,
   output logic [Y_W-1:0] snoopy_y,
   output logic           airborne,
   output logic           landed
);
   localparam int TAKEOFF_Y_I = (GROUND_Y - JUMP_VEL > MIN_Y) ? (GROUND_Y - JUMP_VEL) : MIN_Y;

   localparam logic [Y_W-1:0]         GROUND_Y_L  = Y_W'(GROUND_Y);
   localparam logic [Y_W-1:0]         MIN_Y_L     = Y_W'(MIN_Y);
   localparam logic [Y_W-1:0]         TAKEOFF_Y_L = Y_W'(TAKEOFF_Y_I);
   localparam logic signed [8:0]      GROUND_Y_S  = 9'(GROUND_Y);
   localparam logic signed [8:0]      MIN_Y_S     = 9'(MIN_Y);
   localparam logic signed [VEL_W-1:0] TAKEOFF_VEL = VEL_W'(GRAVITY - JUMP_VEL);
   localparam logic signed [VEL_W:0]  GRAVITY_S   = 6'(GRAVITY);
   localparam logic signed [VEL_W:0]  MAX_FALL_S  = 6'(MAX_FALL_VEL);

   logic [1:0]               state_q, state_d;
   logic [Y_W-1:0]           y_q, y_d;
   logic signed [VEL_W-1:0]  vel_q, vel_d;
   logic                     jump_pending_q, jump_pending_d;
   logic                     landed_q, landed_d;

   logic                     jump_rise;
   logic                     jump_req;
   logic signed [8:0]        y_next;
   logic signed [VEL_W:0]    vel_inc;
   logic signed [VEL_W:0]    vel_fall;

   snoopy_edge_detect u_jump_edge (
      .clock (clock),
      .reset (reset),
      .din   (input_jump),
      .rise  (jump_rise)
   );

   always_comb begin
      // A press in the tick cycle itself counts, so the live edge joins the pending flag.
      jump_req       = jump_pending_q | jump_rise;
      jump_pending_d = frame_tick ? 1'b0 : jump_req;
      y_next         = signed'({2'b00, y_q}) + 9'(vel_q);
      vel_inc        = 6'(vel_q) + GRAVITY_S;
      vel_fall       = (vel_inc > MAX_FALL_S) ? MAX_FALL_S : vel_inc;

      state_d  = state_q;
      y_d      = y_q;
      vel_d    = vel_q;
      landed_d = 1'b0;

      case (state_q)
         S_GROUND: begin
            if (frame_tick) begin
               if (jump_req) begin
                  y_d     = TAKEOFF_Y_L;
                  vel_d   = TAKEOFF_VEL;
                  state_d = TAKEOFF_VEL[VEL_W-1] ? S_RISE : S_FALL;
               end else begin
                  y_d   = GROUND_Y_L;
                  vel_d = '0;
               end
            end
         end
         S_RISE: begin
            if (frame_tick) begin
               if (y_next < MIN_Y_S) begin
                  y_d     = MIN_Y_L;
                  vel_d   = '0;
                  state_d = S_FALL;
               end else begin
                  y_d   = y_next[Y_W-1:0];
                  vel_d = vel_inc[VEL_W-1:0];
                  if (!vel_inc[VEL_W]) begin
                     state_d = S_FALL;
                  end
               end
            end
         end
         S_FALL: begin
            if (frame_tick) begin
               if (y_next >= GROUND_Y_S) begin
                  y_d      = GROUND_Y_L;
                  vel_d    = '0;
                  state_d  = S_GROUND;
                  landed_d = 1'b1;
               end else begin
                  y_d   = y_next[Y_W-1:0];
                  vel_d = vel_fall[VEL_W-1:0];
               end
            end
         end
         default: begin
            state_d = S_GROUND;
            y_d     = GROUND_Y_L;
            vel_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= S_GROUND;
         y_q            <= GROUND_Y_L;
         vel_q          <= '0;
         jump_pending_q <= 1'b0;
         landed_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         y_q            <= y_d;
         vel_q          <= vel_d;
         jump_pending_q <= jump_pending_d;
         landed_q       <= landed_d;
      end
   end

   always_comb begin
      snoopy_y = y_q;
      airborne = (state_q == S_RISE) || (state_q == S_FALL);
      landed   = landed_q;
   end
endmodule

// File: tb/tb_snoopy_vertical_fsm.sv
// Directed bench for snoopy_vertical_fsm: default arc, held button, mid-air
// reset, ceiling clamp and terminal fall velocity on three parameterisations.
module tb_snoopy_vertical_fsm;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic       jump_a = 1'b0, jump_b = 1'b0, jump_c = 1'b0;
   logic [6:0] y_a, y_b, y_c;
   logic       air_a, air_b, air_c;
   logic       landed_a, landed_b, landed_c;

   int total = 0;
   int bad   = 0;
   int land_cnt_a = 0;

   int arc_a [13] = '{94, 89, 85, 82, 80, 79, 79, 80, 82, 85, 89, 94, 100};
   int arc_b [7]  = '{4, 0, 0, 1, 3, 6, 10};
   int arc_c [6]  = '{94, 91, 91, 94, 98, 100};

   always #5 clock = ~clock;

   snoopy_vertical_fsm dut_a (
      .clock(clock), .reset(reset), .frame_tick(frame_tick), .input_jump(jump_a),
      .snoopy_y(y_a), .airborne(air_a), .landed(landed_a)
   );

   snoopy_vertical_fsm #(.GROUND_Y(10), .MIN_Y(0), .JUMP_VEL(6)) dut_b (
      .clock(clock), .reset(reset), .frame_tick(frame_tick), .input_jump(jump_b),
      .snoopy_y(y_b), .airborne(air_b), .landed(landed_b)
   );

   snoopy_vertical_fsm #(.GRAVITY(3), .MAX_FALL_VEL(4)) dut_c (
      .clock(clock), .reset(reset), .frame_tick(frame_tick), .input_jump(jump_c),
      .snoopy_y(y_c), .airborne(air_c), .landed(landed_c)
   );

   always @(posedge clock) begin
      if (landed_a) land_cnt_a <= land_cnt_a + 1;
   end

   task automatic chk(input string tag, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic tick();
      @(negedge clock);
      frame_tick = 1'b1;
      @(posedge clock);
      #1;
      frame_tick = 1'b0;
   endtask

   initial begin
      int prev_y;
      int step;

      repeat (3) cyc();
      reset = 1'b0;
      chk("rst_y_a", y_a, 100);
      chk("rst_air_a", air_a, 0);
      chk("rst_landed_a", landed_a, 0);
      chk("rst_y_b", y_b, 10);
      chk("rst_y_c", y_c, 100);

      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("idle_y%0d", i), y_a, 100);
         chk($sformatf("idle_air%0d", i), air_a, 0);
      end
      cyc();
      chk("idle_land_cnt", land_cnt_a, 0);

      // full default arc, button held throughout
      jump_a = 1'b1;
      for (int i = 0; i < 13; i++) begin
         tick();
         chk($sformatf("arc_y%0d", i), y_a, arc_a[i]);
         chk($sformatf("arc_air%0d", i), air_a, (i < 12) ? 1 : 0);
         chk($sformatf("arc_landed%0d", i), landed_a, (i == 12) ? 1 : 0);
         if (i == 4) chk("arc_state_t5", dut_a.state_q, 1);
         if (i == 5) chk("arc_state_t6", dut_a.state_q, 2);
      end
      cyc();
      chk("arc_landed_after", landed_a, 0);
      chk("arc_land_cnt", land_cnt_a, 1);

      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("held_y%0d", i), y_a, 100);
         chk($sformatf("held_air%0d", i), air_a, 0);
      end

      jump_a = 1'b0;
      cyc();
      jump_a = 1'b1;
      tick();
      chk("repress_y", y_a, 94);
      jump_a = 1'b0;
      tick();
      chk("arc2_y1", y_a, 89);
      tick();
      chk("arc2_y2", y_a, 85);
      // mid-air press must be dropped
      jump_a = 1'b1;
      cyc();
      jump_a = 1'b0;
      for (int i = 3; i < 13; i++) begin
         tick();
         chk($sformatf("arc2_y%0d", i), y_a, arc_a[i]);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         chk($sformatf("post2_y%0d", i), y_a, 100);
         chk($sformatf("post2_air%0d", i), air_a, 0);
      end
      chk("arc2_land_cnt", land_cnt_a, 2);

      jump_a = 1'b1;
      tick();
      jump_a = 1'b0;
      tick();
      tick();
      chk("rmid_y3", y_a, 85);
      @(negedge clock);
      frame_tick = 1'b1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      frame_tick = 1'b0;
      reset = 1'b0;
      chk("rmid_y", y_a, 100);
      chk("rmid_air", air_a, 0);
      chk("rmid_state", dut_a.state_q, 0);
      chk("rmid_landed", landed_a, 0);
      cyc();
      chk("rmid_landed2", landed_a, 0);
      chk("rmid_land_cnt", land_cnt_a, 2);

      jump_b = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         jump_b = 1'b0;
         chk($sformatf("ceil_y%0d", i), y_b, arc_b[i]);
         chk($sformatf("ceil_landed%0d", i), landed_b, (i == 6) ? 1 : 0);
         if (i == 1) begin
            chk("ceil_state", dut_b.state_q, 2);
            chk("ceil_vel", dut_b.vel_q, 0);
            chk("ceil_air", air_b, 1);
         end
      end

      // press and release entirely between ticks
      cyc();
      @(negedge clock);
      jump_c = 1'b1;
      @(negedge clock);
      jump_c = 1'b0;
      cyc();
      prev_y = 100;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("grav_y%0d", i), y_c, arc_c[i]);
         step = int'(y_c) - prev_y;
         if (step > 0) chk($sformatf("grav_step%0d", i), (step <= 4) ? 1 : 0, 1);
         prev_y = int'(y_c);
      end
      chk("grav_landed", landed_c, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/snoopy_vertical_fsm.md
# snoopy_vertical_fsm

Vertical-axis motion controller for Snoopy: turns a jump button into a gravity-driven jump arc and drives the sprite's y coordinate. It is the vertical counterpart of the horizontal movement FSM and sits beside it between the input synchroniser and the sprite renderer. Together they form Snoopy's (x, y) position on the 160x120 screen, where y grows downward. Motion advances once per frame tick, so arc speed does not depend on the system clock rate.

## Interface
Parameters:
- GROUND_Y, 100: resting y (pixels); must be < 120
- MIN_Y, 0: ceiling y; upward motion clamps here
- JUMP_VEL, 6: take-off speed (pixels/tick, magnitude), 1..15
- GRAVITY, 1: velocity increment per tick, 1..15
- MAX_FALL_VEL, 6: terminal downward speed, 1..15

Ports:
- clock  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse per frame; the motion update enable
- input_jump  in  1  jump button, level, already synchronised
- snoopy_y  out  7  current y position
- airborne  out  1  high in S_RISE or S_FALL
- landed  out  1  one-cycle pulse on the tick that returns to ground

## Operation
- States: S_GROUND=2'b00, S_RISE=2'b01, S_FALL=2'b10. 2'b11 is illegal and recovers to S_GROUND on the next clock.
- Registers:
  - y: 7-bit unsigned
  - vel: 5-bit signed; negative means up
  - jump_pending: 1 bit
  - jump_prev: 1 bit
- Jump capture, every clock:
  - a rising edge of input_jump (input_jump & ~jump_prev) sets jump_pending
  - jump_pending clears on every frame_tick, whether or not it was used
  - holding the button never retriggers; a new press is needed after landing
- Updates happen only on clocks with frame_tick=1. Compute y_next = y + vel in 9-bit signed.
- S_GROUND:
  - if jump_pending or a rising edge in this same cycle: y <= max(GROUND_Y − JUMP_VEL, MIN_Y), vel <= −JUMP_VEL + GRAVITY
  - next state is S_RISE if the new vel < 0, else S_FALL
  - no jump: hold y=GROUND_Y, vel=0
- S_RISE:
  - if y_next < MIN_Y: y <= MIN_Y, vel <= 0, go to S_FALL (ceiling bump)
  - else y <= y_next, vel <= vel + GRAVITY; go to S_FALL if vel + GRAVITY ≥ 0
- S_FALL:
  - if y_next ≥ GROUND_Y: y <= GROUND_Y, vel <= 0, go to S_GROUND, landed=1
  - else y <= y_next, vel <= min(vel + GRAVITY, MAX_FALL_VEL)
- Jump presses while airborne are ignored; the pending flag is cleared at the next tick.
- Velocity arithmetic uses a 6-bit signed intermediate, so it cannot overflow within the legal parameter range.

## Timing
- Reset, including mid-air: state=S_GROUND, y=GROUND_Y, vel=0, jump_pending=0, jump_prev=0, landed=0. Reset wins over frame_tick in the same cycle.
- Outputs are registered:
  - snoopy_y reflects an update on the clock after the frame_tick edge (latency 1)
  - airborne is decoded from the state register
  - landed is registered, high for exactly the one cycle after the landing tick, low otherwise
- A press and a tick in the same cycle in S_GROUND take off on that tick.
- A press that is released before the next tick still causes a jump.
- With the defaults the full arc is 13 ticks from take-off to landing, with apex y=79.

## Structure
- Shared package snoopy_pkg holds:
  - SCREEN_W=160, SCREEN_H=120, and the X_W=8 / Y_W=7 coordinate widths
  - vertical state encodings, so the renderer and the collision logic can decode them
- Sub-module snoopy_edge_detect: a one-bit registered rising-edge detector producing a synchronous pulse. It can be reused for the horizontal buttons.
- Everything else is one sequential process plus combinational next-state logic.

## Test plan
- Reset, then 5 ticks with no jump -> y=100, airborne=0, landed never pulses.
- Defaults; press jump, then tick repeatedly:
  - y sequence 94, 89, 85, 82, 80, 79, 79, 80, 82, 85, 89, 94, 100
  - S_RISE→S_FALL at the 6th tick
  - landed pulses once after the 13th tick
- Hold input_jump high through landing and 5 further ticks -> no second jump. Release, then press -> jump starts at the next tick.
- GROUND_Y=10, MIN_Y=0, JUMP_VEL=6:
  - press and tick: y = 4, then 0 (ceiling clamp, vel=0, S_FALL)
  - then 0, 1, 3, 6, 10, landing
- Assert reset at the 4th tick of a jump -> next cycle y=100, S_GROUND, airborne=0, no landed pulse.
- GRAVITY=3, MAX_FALL_VEL=4 -> downward step never exceeds 4 pixels per tick. Separately, a press between ticks then released before the tick -> jump still taken.
